// File: rtl/vx_barrier_ctrl_pkg.sv
// Shared sizing, descriptor types and per-barrier state encoding for the
// warp barrier controller.
package vx_barrier_ctrl_pkg;

    localparam int NW_WIDTH       = 4;
    localparam int NB_WIDTH       = 2;
    localparam int ISSUE_WIDTH    = 2;
    localparam int NUM_WARPS_DFLT = 1 << NW_WIDTH;
    localparam int CW             = NW_WIDTH + 1;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
        logic                is_global;
        logic [NW_WIDTH-1:0] size_m1;
        logic                is_noop;
    } barrier_t;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
    } gbar_req_t;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
    } gbar_rsp_t;

    typedef enum logic [1:0] {
        BAR_IDLE    = 2'd0,
        BAR_COLLECT = 2'd1,
        BAR_GREQ    = 2'd2,
        BAR_GWAIT   = 2'd3
    } bar_state_e;

endpackage

// File: rtl/vx_barrier_ctrl_entry.sv
// One barrier table slot: wait mask, arrival count, latched descriptor and
// the slot's collect / global-handshake state.
//   state   | meaning
//   IDLE    | empty; if rel_q is set the mask is the release shown this cycle
//   COLLECT | at least one warp waiting, target count not yet reached
//   GREQ    | global barrier complete locally, request pending to the sync
//   GWAIT   | request accepted, waiting for the matching completion response
module vx_barrier_ctrl_entry
    import vx_barrier_ctrl_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DFLT
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NUM_WARPS-1:0] acc_mask_i,
    input  logic [CW-1:0]        cnt_i,
    input  logic [NW_WIDTH-1:0]  size_m1_i,
    input  logic                 global_i,
    input  logic                 done_i,
    input  logic                 gnt_i,
    input  logic                 rsp_hit_i,
    output bar_state_e           state_o,
    output logic [NUM_WARPS-1:0] mask_o,
    output logic [CW-1:0]        cnt_o,
    output logic [NW_WIDTH-1:0]  size_m1_o,
    output logic                 global_o,
    output logic                 rel_o
);

    bar_state_e           state_q, state_d;
    logic [NUM_WARPS-1:0] mask_q, mask_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NW_WIDTH-1:0]  size_q, size_d;
    logic                 glob_q, glob_d;
    logic                 rel_q, rel_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= BAR_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            glob_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            glob_q  <= glob_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        glob_d  = glob_q;
        rel_d   = 1'b0;
        // The released mask lives exactly one cycle; new arrivals start afresh.
        if (rel_q) begin
            mask_d = '0;
            cnt_d  = '0;
        end
        case (state_q)
            BAR_IDLE, BAR_COLLECT: begin
                if (|acc_mask_i) begin
                    mask_d  = mask_d | acc_mask_i;
                    cnt_d   = cnt_i;
                    size_d  = size_m1_i;
                    glob_d  = global_i;
                    state_d = BAR_COLLECT;
                    if (done_i) begin
                        if (global_i) begin
                            state_d = BAR_GREQ;
                        end else begin
                            state_d = BAR_IDLE;
                            rel_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            BAR_GREQ: begin
                if (gnt_i) state_d = BAR_GWAIT;
            end
            BAR_GWAIT: begin
                if (rsp_hit_i) begin
                    state_d = BAR_IDLE;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = BAR_IDLE;
        endcase
    end

    assign state_o   = state_q;
    assign mask_o    = mask_q;
    assign cnt_o     = cnt_q;
    assign size_m1_o = size_q;
    assign global_o  = glob_q;
    assign rel_o     = rel_q;

endmodule

// File: rtl/vx_barrier_ctrl.sv
// Warp barrier controller: accepts per-channel warp arrivals, releases locally
// completed barriers and hands global ones to an external synchroniser.
module vx_barrier_ctrl
    import vx_barrier_ctrl_pkg::*;
#(
    parameter int NUM_WARPS    = NUM_WARPS_DFLT,
    parameter int NUM_BARRIERS = 1 << NB_WIDTH,
    parameter int NUM_REQS     = ISSUE_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [NUM_REQS-1:0]               arr_valid_i,
    input  logic [NUM_REQS-1:0][NW_WIDTH-1:0] arr_wid_i,
    input  barrier_t [NUM_REQS-1:0]           arr_bar_i,
    output logic                              release_valid_o,
    output logic [NUM_WARPS-1:0]              release_wmask_o,
    output logic [NUM_WARPS-1:0]              stalled_wmask_o,
    output logic                              gbar_req_valid_o,
    output logic [NB_WIDTH-1:0]               gbar_req_id_o,
    input  logic                              gbar_req_ready_i,
    input  logic                              gbar_rsp_valid_i,
    input  logic [NB_WIDTH-1:0]               gbar_rsp_id_i,
    output logic                              err_valid_o
);

    bar_state_e           state    [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] mask     [NUM_BARRIERS];
    logic [CW-1:0]        cnt      [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  size_m1  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] acc_mask [NUM_BARRIERS];
    logic [CW-1:0]        cnt_w    [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  size_w   [NUM_BARRIERS];

    logic [NUM_BARRIERS-1:0] glob, rel, glob_w, full, fresh, open_w;
    logic [NUM_BARRIERS-1:0] greq, gnt, rsp_hit;
    logic [NUM_WARPS-1:0]    stalled, released, taken, wbit;
    logic [NB_WIDTH-1:0]     pe;
    logic                    hit, err_arr, err_rsp;
    gbar_req_t               req_sel;
    gbar_rsp_t               rsp;

    logic                    err_q, err_d;
    logic                    lock_q, lock_d;
    logic [NB_WIDTH-1:0]     lock_id_q, lock_id_d;

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_entry
        vx_barrier_ctrl_entry #(.NUM_WARPS(NUM_WARPS)) u_entry (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .acc_mask_i (acc_mask[g]),
            .cnt_i      (cnt_w[g]),
            .size_m1_i  (size_w[g]),
            .global_i   (glob_w[g]),
            .done_i     (full[g]),
            .gnt_i      (gnt[g]),
            .rsp_hit_i  (rsp_hit[g]),
            .state_o    (state[g]),
            .mask_o     (mask[g]),
            .cnt_o      (cnt[g]),
            .size_m1_o  (size_m1[g]),
            .global_o   (glob[g]),
            .rel_o      (rel[g])
        );
    end

    always_comb begin
        stalled  = '0;
        released = '0;
        greq     = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            stalled |= mask[b];
            if (rel[b]) released |= mask[b];
            greq[b] = (state[b] == BAR_GREQ);
        end
    end

    // Channels are walked in order so earlier accepted arrivals block later
    // duplicates and overflow of the same cycle.
    always_comb begin
        taken   = '0;
        wbit    = '0;
        hit     = 1'b0;
        err_arr = 1'b0;
        fresh   = '0;
        open_w  = '0;
        full    = '0;
        glob_w  = glob;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            fresh[b]    = rel[b] || (state[b] == BAR_IDLE);
            open_w[b]   = fresh[b] || (state[b] == BAR_COLLECT);
            cnt_w[b]    = rel[b] ? '0 : cnt[b];
            size_w[b]   = size_m1[b];
            acc_mask[b] = '0;
        end
        for (int c = 0; c < NUM_REQS; c++) begin
            if (arr_valid_i[c] && !arr_bar_i[c].is_noop) begin
                wbit = '0;
                wbit[arr_wid_i[c]] = 1'b1;
                hit = 1'b0;
                for (int b = 0; b < NUM_BARRIERS; b++) begin
                    if (arr_bar_i[c].id == NB_WIDTH'(b)) begin
                        hit = 1'b1;
                        if (|((stalled | taken) & wbit) || !open_w[b] || full[b]) begin
                            err_arr = 1'b1;
                        end else begin
                            if (fresh[b]) begin
                                size_w[b] = arr_bar_i[c].size_m1;
                                glob_w[b] = arr_bar_i[c].is_global;
                                fresh[b]  = 1'b0;
                            end else if (arr_bar_i[c].size_m1 != size_w[b]) begin
                                err_arr = 1'b1;
                            end
                            taken       = taken | wbit;
                            acc_mask[b] = acc_mask[b] | wbit;
                            cnt_w[b]    = cnt_w[b] + CW'(1);
                            if (cnt_w[b] == CW'(size_w[b]) + CW'(1)) full[b] = 1'b1;
                        end
                    end
                end
                if (!hit) err_arr = 1'b1;
            end
        end
    end

    assign rsp = '{id: gbar_rsp_id_i};

    always_comb begin
        rsp_hit = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            rsp_hit[b] = gbar_rsp_valid_i && (rsp.id == NB_WIDTH'(b)) && (state[b] == BAR_GWAIT);
        end
        err_rsp = gbar_rsp_valid_i && !(|rsp_hit);
    end

    // Fixed priority picks the lowest pending barrier; once a request is shown
    // without ready it is pinned so the id cannot change under the requester.
    always_comb begin
        pe = '0;
        for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
            if (greq[b]) pe = NB_WIDTH'(b);
        end
        req_sel.id = lock_q ? lock_id_q : pe;
    end

    assign gbar_req_valid_o = lock_q || (|greq);
    assign gbar_req_id_o    = req_sel.id;

    always_comb begin
        gnt = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            gnt[b] = gbar_req_valid_o && gbar_req_ready_i && (req_sel.id == NB_WIDTH'(b));
        end
        lock_d    = gbar_req_valid_o && !gbar_req_ready_i;
        lock_id_d = req_sel.id;
        err_d     = err_arr || err_rsp;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q     <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            err_q     <= err_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign release_valid_o = |rel;
    assign release_wmask_o = released;
    assign stalled_wmask_o = stalled;
    assign err_valid_o     = err_q;

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Directed barrier scenarios followed by randomized local-barrier rounds
// checked against a set-level arrival/completion model.
module tb_vx_barrier_ctrl;
    import vx_barrier_ctrl_pkg::*;

    localparam int NW = 16;
    localparam int NR = 2;
    localparam int NB = 4;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [NR-1:0]                arr_valid;
    logic [NR-1:0][NW_WIDTH-1:0]  arr_wid;
    barrier_t [NR-1:0]            arr_bar;
    logic                         release_valid;
    logic [NW-1:0]                release_wmask, stalled_wmask;
    logic                         req_valid, req_ready, rsp_valid, err_valid;
    logic [NB_WIDTH-1:0]          req_id, rsp_id;

    int n_chk = 0;
    int n_pass = 0;

    int bi, j, k, w, e, nb, base, tmp;
    logic [NW-1:0] freew, exp_rel, exp_st;
    logic [NW-1:0] bmask [3];
    logic [NW-1:0] amask [3];
    int bidx [3];
    int bsize [3];
    int acnt [3];
    int done_at [3];
    int qb [$];
    int qw [$];

    always #5 clk = ~clk;

    vx_barrier_ctrl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB), .NUM_REQS(NR)) dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .arr_valid_i      (arr_valid),
        .arr_wid_i        (arr_wid),
        .arr_bar_i        (arr_bar),
        .release_valid_o  (release_valid),
        .release_wmask_o  (release_wmask),
        .stalled_wmask_o  (stalled_wmask),
        .gbar_req_valid_o (req_valid),
        .gbar_req_id_o    (req_id),
        .gbar_req_ready_i (req_ready),
        .gbar_rsp_valid_i (rsp_valid),
        .gbar_rsp_id_i    (rsp_id),
        .err_valid_o      (err_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_arr();
        arr_valid = '0;
        arr_wid   = '0;
        arr_bar   = '0;
    endtask

    task automatic set_arr(input int ch, input int wid, input int id, input bit glob, input int sm1);
        arr_valid[ch] = 1'b1;
        arr_wid[ch]   = NW_WIDTH'(wid);
        arr_bar[ch]   = '{id: NB_WIDTH'(id), is_global: glob, size_m1: NW_WIDTH'(sm1), is_noop: 1'b0};
    endtask

    initial begin
        rst_n = 1'b0;
        clr_arr();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        #12;
        check("rst_rv", release_valid, 0);
        check("rst_rm", release_wmask, 0);
        check("rst_st", stalled_wmask, 0);
        check("rst_req", req_valid, 0);
        check("rst_err", err_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // local barrier 1, four warps on successive cycles
        for (int wl = 0; wl < 4; wl++) begin
            set_arr(0, wl, 1, 1'b0, 3);
            tick();
            clr_arr();
            check("loc_stall", stalled_wmask, (1 << (wl + 1)) - 1);
            check("loc_rel", release_wmask, (wl == 3) ? 32'hF : 32'h0);
        end
        tick();
        check("loc_stall_after", stalled_wmask, 0);
        check("loc_rv_after", release_valid, 0);

        // parallel arrival on both channels
        set_arr(0, 4, 2, 1'b0, 1);
        set_arr(1, 5, 2, 1'b0, 1);
        tick();
        clr_arr();
        check("par_rel", release_wmask, 32'h30);
        check("par_rv", release_valid, 1);
        check("par_err", err_valid, 0);
        tick();
        check("par_stall", stalled_wmask, 0);

        // noop arrival of size 1 would otherwise release at once
        set_arr(0, 6, 0, 1'b0, 0);
        arr_bar[0].is_noop = 1'b1;
        tick();
        clr_arr();
        check("noop_stall", stalled_wmask, 0);
        check("noop_rv", release_valid, 0);
        check("noop_err", err_valid, 0);

        // global barrier with back-pressured request
        set_arr(0, 0, 0, 1'b1, 1);
        tick();
        set_arr(0, 1, 0, 1'b1, 1);
        tick();
        clr_arr();
        check("glb_stall", stalled_wmask, 32'h3);
        check("glb_rv", release_valid, 0);
        check("glb_req", req_valid, 1);
        check("glb_id", req_id, 0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            check("glb_req_hold", req_valid, 1);
            check("glb_id_hold", req_id, 0);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("glb_req_done", req_valid, 0);
        check("glb_gwait_rv", release_valid, 0);
        rsp_valid = 1'b1;
        rsp_id    = 0;
        tick();
        rsp_valid = 1'b0;
        check("glb_rel", release_wmask, 32'h3);
        check("glb_err", err_valid, 0);
        tick();
        check("glb_stall_after", stalled_wmask, 0);

        // duplicate warp: one error pulse, count not advanced
        set_arr(0, 2, 3, 1'b0, 3);
        tick();
        set_arr(0, 2, 3, 1'b0, 3);
        tick();
        clr_arr();
        check("dup_err", err_valid, 1);
        check("dup_stall", stalled_wmask, 32'h4);
        tick();
        check("dup_err_pulse", err_valid, 0);
        set_arr(0, 7, 3, 1'b0, 3);
        tick();
        set_arr(0, 8, 3, 1'b0, 3);
        tick();
        clr_arr();
        check("dup_cnt", release_valid, 0);
        set_arr(0, 9, 3, 1'b0, 3);
        tick();
        clr_arr();
        check("dup_rel", release_wmask, 32'h384);
        tick();
        rsp_valid = 1'b1;
        rsp_id    = 1;
        tick();
        rsp_valid = 1'b0;
        check("rsp_idle_err", err_valid, 1);
        check("rsp_idle_rv", release_valid, 0);
        tick();

        // overflow in one cycle: second arrival dropped
        set_arr(0, 10, 1, 1'b0, 0);
        set_arr(1, 11, 1, 1'b0, 0);
        tick();
        clr_arr();
        check("ovf_rel", release_wmask, 32'h400);
        check("ovf_err", err_valid, 1);
        tick();
        check("ovf_stall", stalled_wmask, 0);

        // size mismatch: latched size wins
        set_arr(0, 12, 2, 1'b0, 1);
        tick();
        set_arr(0, 13, 2, 1'b0, 3);
        tick();
        clr_arr();
        check("mis_err", err_valid, 1);
        check("mis_rel", release_wmask, 32'h3000);
        tick();

        // local completion and global response in the same cycle
        set_arr(0, 0, 0, 1'b1, 0);
        tick();
        clr_arr();
        check("cc_req", req_valid, 1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        set_arr(0, 1, 1, 1'b0, 1);
        tick();
        set_arr(0, 2, 1, 1'b0, 1);
        rsp_valid = 1'b1;
        rsp_id    = 0;
        tick();
        clr_arr();
        rsp_valid = 1'b0;
        check("cc_rel", release_wmask, 32'h7);
        check("cc_err", err_valid, 0);
        tick();
        check("cc_stall", stalled_wmask, 0);

        // priority among pending global requests and id pinning
        set_arr(0, 4, 2, 1'b1, 0);
        set_arr(1, 5, 1, 1'b1, 0);
        tick();
        clr_arr();
        check("pri_id_first", req_id, 1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("pri_valid_second", req_valid, 1);
        check("pri_id_second", req_id, 2);
        set_arr(0, 6, 0, 1'b1, 0);
        tick();
        clr_arr();
        check("pri_id_pinned", req_id, 2);
        req_ready = 1'b1;
        tick();
        check("pri_id_third", req_id, 0);
        tick();
        req_ready = 1'b0;
        check("pri_valid_none", req_valid, 0);
        check("pri_stall", stalled_wmask, 32'h70);
        rsp_valid = 1'b1;
        rsp_id    = 2;
        tick();
        check("pri_rel2", release_wmask, 32'h10);
        rsp_id = 1;
        tick();
        check("pri_rel1", release_wmask, 32'h20);
        rsp_id = 0;
        tick();
        rsp_valid = 1'b0;
        check("pri_rel0", release_wmask, 32'h40);
        check("pri_err", err_valid, 0);
        tick();
        check("pri_stall_after", stalled_wmask, 0);

        // reset while barrier 0 waits for its global response
        set_arr(0, 3, 0, 1'b1, 0);
        tick();
        clr_arr();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("rr_stall_pre", stalled_wmask, 32'h8);
        rst_n = 1'b0;
        #1;
        check("rr_rv", release_valid, 0);
        check("rr_rm", release_wmask, 0);
        check("rr_st", stalled_wmask, 0);
        check("rr_req", req_valid, 0);
        check("rr_err0", err_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rsp_valid = 1'b1;
        rsp_id    = 0;
        tick();
        rsp_valid = 1'b0;
        check("rr_err", err_valid, 1);
        check("rr_rel", release_valid, 0);
        tick();

        // randomized rounds of legal local barriers
        for (int r = 0; r < 25; r++) begin
            nb    = $urandom_range(1, 3);
            base  = $urandom_range(0, NB - 1);
            freew = '1;
            qb.delete();
            qw.delete();
            for (int i = 0; i < nb; i++) begin
                bidx[i]    = (base + i) % NB;
                bmask[i]   = '0;
                amask[i]   = '0;
                acnt[i]    = 0;
                done_at[i] = -1;
                bsize[i]   = $urandom_range(1, 4);
                for (int m = 0; m < bsize[i]; m++) begin
                    w = $urandom_range(0, NW - 1);
                    while (!freew[w]) w = (w + 1) % NW;
                    freew[w]    = 1'b0;
                    bmask[i][w] = 1'b1;
                    qb.push_back(i);
                    qw.push_back(w);
                end
            end
            for (int s = qb.size() - 1; s > 0; s--) begin
                j = $urandom_range(0, s);
                tmp = qb[s]; qb[s] = qb[j]; qb[j] = tmp;
                tmp = qw[s]; qw[s] = qw[j]; qw[j] = tmp;
            end
            e = 0;
            while (qb.size() > 0 && e < 200) begin
                k = $urandom_range(0, NR);
                for (int c = 0; c < NR; c++) begin
                    if (c < k && qb.size() > 0) begin
                        bi = qb.pop_front();
                        w  = qw.pop_front();
                        set_arr(c, w, bidx[bi], 1'b0, bsize[bi] - 1);
                        amask[bi][w] = 1'b1;
                        acnt[bi]++;
                        if (acnt[bi] == bsize[bi]) done_at[bi] = e;
                    end
                end
                tick();
                clr_arr();
                exp_rel = '0;
                exp_st  = '0;
                for (int i = 0; i < nb; i++) begin
                    if (done_at[i] == e) exp_rel |= bmask[i];
                    if (done_at[i] == -1 || done_at[i] == e) exp_st |= amask[i];
                end
                check("rnd_rel", release_wmask, exp_rel);
                check("rnd_rv", release_valid, exp_rel != '0);
                check("rnd_stall", stalled_wmask, exp_st);
                check("rnd_err", err_valid, 0);
                e++;
            end
            tick();
            check("rnd_idle_stall", stalled_wmask, 0);
            check("rnd_idle_rv", release_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
